me_result_collector: RTL and testbench
======================================

// Module: me_result_collector
// PURPOSE
//  Downstream stage of the motion-estimation top (`top`). Detects each completion of a block search on
//  `completed` and captures BestDist/motionX/motionY together with a block sequence tag.
//  Buffers results in a small FIFO and presents them to the consumer (vector writer or scoreboard)
//  over a valid/ready handshake. This decouples the estimator's one-cycle result window from a slow sink.
// PARAMETERS
//  DIST_W  8  width of BestDist / out_dist
//  MV_W    4  width of motionX/motionY (two's complement)
//  DEPTH   4  FIFO entries; power of two, >=2
//  TAG_W   8  width of block sequence tag
// PORTS
//  clock      in   1               system clock, rising edge
//  reset      in   1               synchronous, active-high
//  completed  in   1               estimator done level
//  BestDist   in   DIST_W          best SAD for current block
//  motionX    in   MV_W            motion vector X
//  motionY    in   MV_W            motion vector Y
//  out_valid  out  1               head entry available
//  out_ready  in   1               consumer accepts head entry
//  out_dist   out  DIST_W          head BestDist
//  out_mvx    out  MV_W            head motionX
//  out_mvy    out  MV_W            head motionY
//  out_tag    out  TAG_W           head block sequence tag
//  count      out  $clog2(DEPTH)+1 occupied entries
//  overflow   out  1               sticky: a result was dropped
// BEHAVIOUR
//  Reset: FSM=WAIT_CLEAR, tag=0, FIFO empty. out_valid=0, count=0, overflow=0.
//   Data outputs read 0 when empty.
//  FSM, 2 states:
//   WAIT_CLEAR: completed==0 -> WAIT_DONE; otherwise stay.
//    Purpose: a completed level that is already high out of reset is never captured.
//   WAIT_DONE: completed==1 -> capture event, go to WAIT_CLEAR.
//  Capture event (cycle N, completed sampled high):
//   Push {BestDist,motionX,motionY,tag} at edge N; tag <= tag+1, wrapping mod 2^TAG_W.
//   Inputs are sampled in the same cycle completed is first seen high.
//  Latency: out_valid=1 in cycle N+1 when FIFO was empty. No same-cycle bypass.
//  Pop: out_valid && out_ready at an edge removes the head.
//   out_* are stable while out_valid=1 and out_ready=0.
//  Full: a capture with count==DEPTH and no pop is dropped. overflow<=1 (cleared only by reset).
//   Tag still increments, so the consumer sees the gap.
//  Full with simultaneous pop: the push is accepted and count stays at DEPTH.
//  Empty with out_ready=1: nothing popped, count stays 0.
//  Simultaneous push and pop, not full: count unchanged; the pushed entry goes to the tail.
//  Reset mid-operation: all contents discarded and state returns to reset values next cycle.
//   An in-progress completed pulse is not captured (WAIT_CLEAR).
//  Pointers are log2(DEPTH) bits and wrap; count is kept explicitly. No arithmetic on payload.
// CONFIGURATION
//  ME_RESULT_ZERO_MV_EN defined:
//   Adds output zero_mv_cnt [TAG_W-1:0], reset 0.
//   Increments on each capture event with motionX==0 && motionY==0, including dropped captures.
//   Saturates at all-ones.
//  Undefined: the port and counter do not exist; all other behaviour is identical.
// TESTING
//  T1 single result: completed 0->1 with BestDist=8'h2A, mvx=4'h3, mvy=4'hE, out_ready=1
//     -> next cycle out_valid=1 with dist 2A, mvx 3, mvy E (-2), tag 0; popped; count back to 0.
//  T2 level hold: completed held high 10 cycles -> exactly one entry.
//     Drop low 1 cycle then high -> second entry, tag 1.
//  T3 overflow: out_ready=0, 5 completion pulses, DEPTH=4
//     -> count=4, overflow=1, entries tags 0..3.
//     Then drain -> tags 0,1,2,3 in order; next capture gets tag 5.
//  T4 full plus simultaneous pop: FIFO full, completion and out_ready=1 same cycle
//     -> count stays 4, overflow stays 0, new entry is last out.
//  T5 reset: completed high during reset, release reset with completed still high
//     -> no capture until completed falls and rises again.
//     Reset while count=3 -> count=0, out_valid=0 next cycle.
//  T6 (ME_RESULT_ZERO_MV_EN): 3 captures with mv (0,0),(1,0),(0,0) -> zero_mv_cnt=2.

Source files
------------

// File: rtl/me_result_collector.sv
// me_result_collector
//   Captures one {BestDist, motionX, motionY, tag} result per rising completion of
//   the motion estimator and buffers it in a DEPTH-entry FIFO. The consumer drains
//   the FIFO over a valid/ready handshake.
//   Optional build macro: ME_RESULT_ZERO_MV_EN adds the zero_mv_cnt output, which
//   counts captures whose motion vector is (0,0).
//
//   state      | meaning
//   -----------+----------------------------------------------------------
//   WAIT_CLEAR | completed must be seen low before the next capture is armed
//   WAIT_DONE  | armed; the first cycle with completed high is captured
module me_result_collector #(
   parameter int DIST_W = 8,
   parameter int MV_W   = 4,
   parameter int DEPTH  = 4,
   parameter int TAG_W  = 8
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     completed,
   input  logic [DIST_W-1:0]        BestDist,
   input  logic [MV_W-1:0]          motionX,
   input  logic [MV_W-1:0]          motionY,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DIST_W-1:0]        out_dist,
   output logic [MV_W-1:0]          out_mvx,
   output logic [MV_W-1:0]          out_mvy,
   output logic [TAG_W-1:0]         out_tag,
   output logic [$clog2(DEPTH):0]   count,
`ifdef ME_RESULT_ZERO_MV_EN
   output logic [TAG_W-1:0]         zero_mv_cnt,
`endif
   output logic                     overflow
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int ENT_W = DIST_W + 2*MV_W + TAG_W;

   typedef enum logic {
      WAIT_CLEAR = 1'b0,
      WAIT_DONE  = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic               capture;
   logic               pop;
   logic               full;
   logic               push_ok;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [TAG_W-1:0]   tag_q, tag_d;
   logic               overflow_q, overflow_d;
   logic [ENT_W-1:0]   mem_q [DEPTH];
   logic [ENT_W-1:0]   mem_d [DEPTH];
   logic [ENT_W-1:0]   head;
   logic [ENT_W-1:0]   entry_in;

   // FSM state register
   always_ff @(posedge clock) begin
      if (reset) state_q <= WAIT_CLEAR;
      else       state_q <= state_d;
   end

   // FSM next state: re-arm only after completed has been seen low
   always_comb begin
      state_d = state_q;
      case (state_q)
         WAIT_CLEAR: if (!completed) state_d = WAIT_DONE;
         WAIT_DONE:  if (completed)  state_d = WAIT_CLEAR;
         default:    state_d = WAIT_CLEAR;
      endcase
   end

   // FSM output: one capture strobe per completion
   always_comb begin
      capture = 1'b0;
      if (state_q == WAIT_DONE && completed) capture = 1'b1;
   end

   assign out_valid = (count_q != '0);
   assign pop       = out_valid && out_ready;
   assign full      = (count_q == CNT_W'(DEPTH));
   // a pop in the same cycle frees the slot the push needs
   assign push_ok   = capture && (!full || pop);
   assign entry_in  = {BestDist, motionX, motionY, tag_q};

   // FIFO pointers, occupancy, tag and sticky overflow
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      tag_d      = tag_q;
      overflow_d = overflow_q;
      mem_d      = mem_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = entry_in;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
      // tag advances even for a dropped capture so the sink can see the gap
      if (capture) tag_d = tag_q + TAG_W'(1);
      if (capture && !push_ok) overflow_d = 1'b1;
   end

   // FIFO and bookkeeping registers
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         tag_q      <= '0;
         overflow_q <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         tag_q      <= tag_d;
         overflow_q <= overflow_d;
         mem_q      <= mem_d;
      end
   end

`ifdef ME_RESULT_ZERO_MV_EN
   logic [TAG_W-1:0] zmv_q, zmv_d;

   // saturating count of zero-motion captures, dropped ones included
   always_comb begin
      zmv_d = zmv_q;
      if (capture && motionX == '0 && motionY == '0 && zmv_q != '1)
         zmv_d = zmv_q + TAG_W'(1);
   end

   // zero-motion counter register
   always_ff @(posedge clock) begin
      if (reset) zmv_q <= '0;
      else       zmv_q <= zmv_d;
   end

   assign zero_mv_cnt = zmv_q;
`endif

   // head presentation; fields read zero while empty
   always_comb begin
      head     = out_valid ? mem_q[rd_ptr_q] : '0;
      out_dist = head[ENT_W-1 -: DIST_W];
      out_mvx  = head[2*MV_W+TAG_W-1 -: MV_W];
      out_mvy  = head[MV_W+TAG_W-1 -: MV_W];
      out_tag  = head[TAG_W-1:0];
   end

   assign count    = count_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_me_result_collector.sv
// Directed bench for me_result_collector with a scoreboard queue: stimulus pushes
// expected entries, a negedge monitor pops and compares each accepted head entry.
module tb_me_result_collector;

   logic        clock = 1'b0;
   logic        reset;
   logic        completed;
   logic [7:0]  BestDist;
   logic [3:0]  motionX;
   logic [3:0]  motionY;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_dist;
   logic [3:0]  out_mvx;
   logic [3:0]  out_mvy;
   logic [7:0]  out_tag;
   logic [2:0]  count;
   logic        overflow;
`ifdef ME_RESULT_ZERO_MV_EN
   logic [7:0]  zero_mv_cnt;
`endif

   int vectors = 0;
   int miscompares = 0;
   logic [23:0] sb [$];

   me_result_collector dut (
      .clock     (clock),
      .reset     (reset),
      .completed (completed),
      .BestDist  (BestDist),
      .motionX   (motionX),
      .motionY   (motionY),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_dist  (out_dist),
      .out_mvx   (out_mvx),
      .out_mvy   (out_mvy),
      .out_tag   (out_tag),
      .count     (count),
`ifdef ME_RESULT_ZERO_MV_EN
      .zero_mv_cnt (zero_mv_cnt),
`endif
      .overflow  (overflow)
   );

   always #5 clock = ~clock;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // monitor: every handshake beat must match the oldest expected entry
   always @(negedge clock) begin
      if (!reset && out_valid && out_ready) begin
         vectors++;
         if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL pop_unexpected: got %h_%h_%h_%h, expected nothing",
                     out_dist, out_mvx, out_mvy, out_tag);
         end else begin
            logic [23:0] exp_e;
            exp_e = sb.pop_front();
            if ({out_dist, out_mvx, out_mvy, out_tag} !== exp_e) begin
               miscompares++;
               $display("FAIL pop_entry: got %h_%h_%h_%h, expected %h_%h_%h_%h",
                        out_dist, out_mvx, out_mvy, out_tag,
                        exp_e[23:16], exp_e[15:12], exp_e[11:8], exp_e[7:0]);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp_v);
      vectors++;
      if (act != exp_v) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      completed = 1'b0;
      out_ready = 1'b0;
      tick();
      tick();
      sb.delete();
      reset = 1'b0;
      tick();
   endtask

   // one completion pulse: high for one cycle, then low for one cycle
   task automatic pulse(input logic [7:0] d, input logic [3:0] x, input logic [3:0] y,
                        input logic [7:0] tag, input bit accepted);
      BestDist = d;
      motionX = x;
      motionY = y;
      completed = 1'b1;
      if (accepted) sb.push_back({d, x, y, tag});
      tick();
      completed = 1'b0;
      tick();
   endtask

   initial begin
      reset = 1'b1;
      completed = 1'b0;
      out_ready = 1'b0;
      BestDist = '0;
      motionX = '0;
      motionY = '0;
      tick();
      tick();
      chk("rst_valid", int'(out_valid), 0);
      chk("rst_count", int'(count), 0);
      chk("rst_overflow", int'(overflow), 0);
      chk("rst_dist", int'(out_dist), 0);
      reset = 1'b0;
      tick();

      // T1 single result, one-cycle latency then popped
      out_ready = 1'b1;
      BestDist = 8'h2A;
      motionX = 4'h3;
      motionY = 4'hE;
      completed = 1'b1;
      sb.push_back({8'h2A, 4'h3, 4'hE, 8'h00});
      tick();
      chk("t1_valid", int'(out_valid), 1);
      chk("t1_count", int'(count), 1);
      chk("t1_mvy", int'(out_mvy), 14);
      completed = 1'b0;
      tick();
      chk("t1_count_after", int'(count), 0);
      chk("t1_valid_after", int'(out_valid), 0);

      // T2 level held for 10 cycles captures once; re-rise captures again
      do_reset();
      BestDist = 8'h11;
      motionX = 4'h1;
      motionY = 4'h2;
      completed = 1'b1;
      sb.push_back({8'h11, 4'h1, 4'h2, 8'h00});
      repeat (10) tick();
      chk("t2_count_hold", int'(count), 1);
      completed = 1'b0;
      tick();
      pulse(8'h22, 4'h4, 4'h5, 8'h01, 1'b1);
      chk("t2_count_two", int'(count), 2);
      out_ready = 1'b1;
      tick();
      tick();
      out_ready = 1'b0;
      chk("t2_drained", int'(count), 0);

      // T3 overflow: five pulses into four slots, then drain, next tag is 5
      do_reset();
      pulse(8'h30, 4'h0, 4'h1, 8'h00, 1'b1);
      pulse(8'h31, 4'h1, 4'h2, 8'h01, 1'b1);
      pulse(8'h32, 4'h2, 4'h3, 8'h02, 1'b1);
      pulse(8'h33, 4'h3, 4'h4, 8'h03, 1'b1);
      chk("t3_ovf_before", int'(overflow), 0);
      pulse(8'h34, 4'h4, 4'h5, 8'h04, 1'b0);
      chk("t3_count_full", int'(count), 4);
      chk("t3_overflow", int'(overflow), 1);
      chk("t3_head_tag", int'(out_tag), 0);
      tick();
      chk("t3_head_stable", int'(out_dist), 8'h30);
      out_ready = 1'b1;
      repeat (4) tick();
      out_ready = 1'b0;
      chk("t3_drained", int'(count), 0);
      out_ready = 1'b1;
      pulse(8'h35, 4'h5, 4'h6, 8'h05, 1'b1);
      out_ready = 1'b0;
      chk("t3_count_end", int'(count), 0);
      chk("t3_overflow_sticky", int'(overflow), 1);

      // T4 full with simultaneous push and pop
      do_reset();
      pulse(8'h40, 4'h0, 4'h0, 8'h00, 1'b1);
      pulse(8'h41, 4'h1, 4'h1, 8'h01, 1'b1);
      pulse(8'h42, 4'h2, 4'h2, 8'h02, 1'b1);
      pulse(8'h43, 4'h3, 4'h3, 8'h03, 1'b1);
      chk("t4_full", int'(count), 4);
      BestDist = 8'h44;
      motionX = 4'h4;
      motionY = 4'hC;
      completed = 1'b1;
      out_ready = 1'b1;
      sb.push_back({8'h44, 4'h4, 4'hC, 8'h04});
      tick();
      completed = 1'b0;
      chk("t4_count_stays", int'(count), 4);
      chk("t4_no_overflow", int'(overflow), 0);
      repeat (4) tick();
      chk("t4_drained", int'(count), 0);
      tick();
      chk("t4_empty_ready", int'(count), 0);
      chk("t4_empty_valid", int'(out_valid), 0);
      out_ready = 1'b0;

      // T5 completed high through reset release is not captured
      reset = 1'b1;
      completed = 1'b1;
      BestDist = 8'h50;
      tick();
      tick();
      sb.delete();
      reset = 1'b0;
      repeat (3) tick();
      chk("t5_no_capture", int'(count), 0);
      chk("t5_no_valid", int'(out_valid), 0);
      completed = 1'b0;
      tick();
      pulse(8'h51, 4'h1, 4'h0, 8'h00, 1'b1);
      chk("t5_capture", int'(count), 1);
      pulse(8'h52, 4'h2, 4'h0, 8'h01, 1'b1);
      pulse(8'h53, 4'h3, 4'h0, 8'h02, 1'b1);
      chk("t5_count3", int'(count), 3);
      reset = 1'b1;
      tick();
      sb.delete();
      chk("t5_rst_count", int'(count), 0);
      chk("t5_rst_valid", int'(out_valid), 0);
      chk("t5_rst_dist", int'(out_dist), 0);
      reset = 1'b0;
      tick();

`ifdef ME_RESULT_ZERO_MV_EN
      // T6 zero-motion counter
      do_reset();
      chk("t6_rst_zmv", int'(zero_mv_cnt), 0);
      out_ready = 1'b1;
      pulse(8'h60, 4'h0, 4'h0, 8'h00, 1'b1);
      pulse(8'h61, 4'h1, 4'h0, 8'h01, 1'b1);
      pulse(8'h62, 4'h0, 4'h0, 8'h02, 1'b1);
      out_ready = 1'b0;
      chk("t6_zmv", int'(zero_mv_cnt), 2);
`endif

      tick();
      chk("sb_empty_at_end", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
